aes_sbox_lanes_pipe: RTL and testbench

AES_SBOX_LANES_PIPE -- requirements
Module: aes_sbox_lanes_pipe

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_sbox_byte.sv | 16 +
 rtl/aes_sbox_lanes_pipe.sv | 83 ++++++++
 tb/tb_aes_sbox_lanes_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES S-box tables, lane width and pipeline parameter limits
package aes_pkg;
  localparam int LANE_W     = 8;
  localparam int LANES_MIN  = 1;
  localparam int LANES_MAX  = 16;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
endpackage

// File: rtl/aes_sbox_byte.sv
// aes_sbox_byte: combinational byte substitution; inverse table only when AES_SBOX_INV_EN is defined
module aes_sbox_byte
  import aes_pkg::*;
(
  input  logic [LANE_W-1:0] in_byte,
  input  logic              inv,
  output logic [LANE_W-1:0] out_byte
);
`ifdef AES_SBOX_INV_EN
  assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign out_byte   = SBOX[in_byte];
`endif
endmodule

// File: rtl/aes_sbox_lanes_pipe.sv
// aes_sbox_lanes_pipe: LANES-wide S-box with STAGES-deep valid/ready pipeline; inverse mode via AES_SBOX_INV_EN
module aes_sbox_lanes_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_inv,
  input  logic [LANE_W*LANES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_inv,
  output logic [LANE_W*LANES-1:0] out_data
);
  localparam int W = LANE_W * LANES;
  logic [W-1:0]        sub;
  logic [STAGES-1:0]   valid;
  logic [STAGES-1:0]   rdy;
  logic [STAGES-1:0]   src_valid;
  logic [W-1:0]        data     [STAGES];
  logic [W-1:0]        src_data [STAGES];
`ifdef AES_SBOX_INV_EN
  logic [STAGES-1:0]   inv_q;
  logic [STAGES-1:0]   src_inv;
`endif
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_byte u_sbox (
      .in_byte (in_data[LANE_W*l +: LANE_W]),
      .inv     (in_inv),
      .out_byte(sub[LANE_W*l +: LANE_W])
    );
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         v;
    logic [W-1:0] d;
    // stage k has room unless it and every stage after it are full with the output stalled
    assign rdy[k] = out_ready || !(&valid[STAGES-1:k]);
    if (k == 0) begin : g_head
      assign src_valid[k] = in_valid;
      assign src_data[k]  = sub;
`ifdef AES_SBOX_INV_EN
      assign src_inv[k]   = in_inv;
`endif
    end else begin : g_body
      assign src_valid[k] = valid[k-1];
      assign src_data[k]  = data[k-1];
`ifdef AES_SBOX_INV_EN
      assign src_inv[k]   = inv_q[k-1];
`endif
    end
    // take the predecessor's beat when there is room; data only moves with a real beat
    always_ff @(posedge clk)
      if (rst) begin
        v <= 1'b0;
        d <= '0;
      end else if (rdy[k]) begin
        v <= src_valid[k];
        if (src_valid[k]) d <= src_data[k];
      end
    assign valid[k] = v;
    assign data[k]  = d;
`ifdef AES_SBOX_INV_EN
    logic m;
    // mode bit travels alongside the beat
    always_ff @(posedge clk)
      if (rst) m <= 1'b0;
      else if (rdy[k] && src_valid[k]) m <= src_inv[k];
    assign inv_q[k] = m;
`endif
  end
  assign in_ready  = !rst && rdy[0];
  assign out_valid = !rst && valid[STAGES-1];
  assign out_data  = rst ? '0 : data[STAGES-1];
`ifdef AES_SBOX_INV_EN
  assign out_inv   = !rst && inv_q[STAGES-1];
`else
  assign out_inv   = 1'b0;
`endif
endmodule

// File: tb/tb_aes_sbox_lanes_pipe.sv
// tb_aes_sbox_lanes_pipe: randomized scoreboard bench against a GF(2^8)-derived S-box model
module tb_aes_sbox_lanes_pipe;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int W      = 8 * LANES;
`ifdef AES_SBOX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_inv = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_inv;
  logic [W-1:0] out_data;
  int checks = 0;
  int failures = 0;
  int n_in = 0;
  int n_out = 0;
  logic [7:0] fwd [256];
  logic [7:0] rev [256];
  logic [W:0] sbq [$];
  always #5 clk = ~clk;
  aes_sbox_lanes_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inv   (in_inv),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inv  (out_inv),
    .out_data (out_data)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction
  // S-box from its definition: multiplicative inverse then affine transform
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv;
      logic [7:0] s;
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) iv = y[7:0];
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd[x] = s;
      rev[s] = x[7:0];
    end
  endtask
  function automatic logic [W:0] model(logic [W-1:0] d, logic inv);
    logic [W-1:0] r;
    logic use_inv;
    use_inv = inv & INV_EN;
    for (int l = 0; l < LANES; l++)
      r[8*l +: 8] = use_inv ? rev[d[8*l +: 8]] : fwd[d[8*l +: 8]];
    return {use_inv, r};
  endfunction
  // scoreboard: record accepted beats, compare every emitted beat in order
  always @(negedge clk) begin : mon
    logic [W:0] e;
    if (in_valid && in_ready) begin
      sbq.push_back(model(in_data, in_inv));
      n_in++;
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (sbq.size() == 0) check("sb_unexpected_beat", 1, 0);
      else begin
        e = sbq.pop_front();
        check("sb_data", out_data, e[W-1:0]);
        check("sb_inv", out_inv, e[W]);
      end
    end
  end
  task automatic one_beat(string tag, logic [W-1:0] d, logic inv, logic [W-1:0] exp_d, logic exp_i);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_inv"}, out_inv, exp_i);
  endtask
  initial begin
    int ov, stalls, n0, acc, unstable, have, stale, cyc, i0;
    logic [W-1:0] hold;
    build_tables();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_inv", out_inv, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_data", out_data, 0);
    one_beat("fwd_vec", 32'h53010063, 1'b0, 32'hED7C63FB, 1'b0);
    one_beat("inv_vec", 32'hED7C63FB, 1'b1, INV_EN ? 32'h53010063 : 32'h5510FB0F, INV_EN);
    one_beat("fwd_ff", 32'hFFFFFFFF, 1'b0, 32'h16161616, 1'b0);
    one_beat("inv_00", 32'h00000000, 1'b1, INV_EN ? 32'h52525252 : 32'h63636363, INV_EN);
    repeat (2) @(posedge clk);
    ov = 0; stalls = 0; n0 = n_out;
    @(posedge clk);
    for (int i = 0; i < 256; i++) begin
      #1;
      in_valid = 1'b1; in_data = W'($urandom); in_inv = i[0];
      @(negedge clk);
      if (!in_ready) stalls++;
      if (out_valid) ov++;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    check("stream_stalls", stalls, 0);
    check("stream_out_cycles", ov, 256);
    @(negedge clk);
    check("stream_out_count", n_out - n0, 256);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b1;
    acc = 0; unstable = 0; have = 0; hold = '0;
    for (int c = 0; c < 6; c++) begin
      in_data = W'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        if (have == 0) hold = out_data;
        else if (out_data !== hold) unstable++;
        have = 1;
      end
      @(posedge clk); #1;
    end
    check("stall_accepts", acc, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_seen", have, 1);
    check("stall_stable", unstable, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("full_accept_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_drained", sbq.size(), 0);
    i0 = n_in; cyc = 0;
    while (cyc < 60000 && !((n_in - i0) >= 10000 && sbq.size() == 0)) begin
      @(posedge clk); #1;
      in_valid  = (n_in - i0) < 10000 ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = W'($urandom);
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("rand_in_count", n_in - i0, 10000);
    check("rand_drained", sbq.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = 32'h01020304;
    @(posedge clk); #1;
    in_data = 32'h05060708;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    sbq.delete();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("midrst_release_in_ready", in_ready, 1);
    stale = 0;
    repeat (5) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    check("midrst_no_stale", stale, 0);
    check("midrst_out_data", out_data, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
